// File: rtl/camera_frame_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : camera_frame_ram_pkg
// Brief    : Shared defaults, capture FSM states and byte-lane helper for the
//            camera dual-port frame buffer.
// Revision : 1.0 - initial release
// ============================================================================
package camera_frame_ram_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 87500;
    localparam int ADDR_W_DEF = 17;
    localparam int FCNT_W_DEF = 16;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    function automatic int byte_lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_ram_tdp.sv
`default_nettype none
// ============================================================================
// Module   : frame_ram_tdp
// Brief    : Inferred single-clock dual-port RAM. Port A: byte-enabled
//            write and registered read. Port B: full-word write only.
// Revision : 1.0 - initial release
// ============================================================================
module frame_ram_tdp
    import camera_frame_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                a_en,
    input  logic                a_we,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [AW-1:0]       a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic [DATA_W-1:0]   a_rdata,
    input  logic                b_we,
    input  logic [AW-1:0]       b_addr,
    input  logic [DATA_W-1:0]   b_wdata
);

    localparam int NB = byte_lanes(DATA_W);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    // Non-blocking read returns the pre-write word on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (a_en) begin
            a_rdata <= r_mem[a_addr];
        end
    end

    // Port B is written last so the stream side wins a write/write collision.
    always_ff @(posedge clk) begin
        if (a_we) begin
            for (int i = 0; i < NB; i++) begin
                if (a_be[i]) begin
                    r_mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
                end
            end
        end
        if (b_we) begin
            r_mem[b_addr] <= b_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/camera_frame_ram_dp.sv
`default_nettype none
// ============================================================================
// Module   : camera_frame_ram_dp
// Brief    : Dual-port camera frame buffer: Avalon-MM CPU slave (s1) plus an
//            auto-incrementing stream write sink (s2) with frame tracking.
//            Define CAMERA_FRAME_RAM_OUTREG_EN for a 2-cycle s1 read latency.
// Revision : 1.0 - initial release
// ============================================================================
module camera_frame_ram_dp
    import camera_frame_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int FCNT_W = FCNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic                s1_chipselect,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    input  logic                st_valid,
    input  logic                st_sop,
    input  logic [DATA_W-1:0]   st_data,
    output logic                st_ready,
    input  logic                capture_en,
    output logic                frame_done,
    output logic [FCNT_W-1:0]   frame_cnt,
    output logic                frame_err
);

    localparam int                RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   c_depth = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_one   = ADDR_W'(1);

    // ---------------- s1: CPU slave ----------------
    logic              w_in_range;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic [DATA_W-1:0] w_ram_q;
    logic [DATA_W-1:0] w_rd_data;
    logic              r_rd_valid;
    logic              r_rd_zero;

    assign w_in_range = ({1'b0, s1_address} < c_depth);
    assign w_rd_acc   = s1_chipselect & s1_read & ~s1_write;
    assign w_wr_acc   = s1_chipselect & s1_write & w_in_range;

    // r_rd_zero starts set so readdata is 0 out of reset without resetting the RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_zero  <= 1'b1;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_zero <= ~w_in_range;
            end
        end
    end

    assign w_rd_data = r_rd_zero ? '0 : w_ram_q;

`ifdef CAMERA_FRAME_RAM_OUTREG_EN
    logic [DATA_W-1:0] r_rd_data_q;
    logic              r_rd_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data_q  <= '0;
            r_rd_valid_q <= 1'b0;
        end else begin
            r_rd_valid_q <= r_rd_valid;
            if (r_rd_valid) begin
                r_rd_data_q <= w_rd_data;
            end
        end
    end

    assign s1_readdata      = r_rd_data_q;
    assign s1_readdatavalid = r_rd_valid_q;
`else
    assign s1_readdata      = w_rd_data;
    assign s1_readdatavalid = r_rd_valid;
`endif

    // ---------------- s2: stream sink ----------------
    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic [ADDR_W-1:0] w_b_addr;
    logic              w_b_we;
    logic              w_done;
    logic              w_err;
    logic              w_beat;
    logic              r_st_ready;
    logic              r_frame_done;
    logic              r_frame_err;
    logic [FCNT_W-1:0] r_frame_cnt;

    assign w_beat = st_valid & r_st_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_wr_ptr;
        w_b_addr    = r_wr_ptr;
        w_b_we      = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_beat && st_sop) begin
                    w_b_we      = 1'b1;
                    w_b_addr    = '0;
                    w_ptr_nxt   = c_one;
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (w_beat) begin
                    w_b_we = 1'b1;
                    if (st_sop && (r_wr_ptr != '0)) begin
                        // Unexpected sop: restart the frame at word 0.
                        w_err     = 1'b1;
                        w_b_addr  = '0;
                        w_ptr_nxt = c_one;
                    end else if (r_wr_ptr == c_last) begin
                        w_done      = 1'b1;
                        w_ptr_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_ptr_nxt = r_wr_ptr + c_one;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_st_ready   <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_ptr_nxt;
            r_st_ready   <= capture_en;
            r_frame_done <= w_done;
            r_frame_err  <= w_err;
            r_frame_cnt  <= r_frame_cnt + FCNT_W'(w_done);
        end
    end

    assign st_ready   = r_st_ready;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign frame_cnt  = r_frame_cnt;

    frame_ram_tdp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .a_en    (w_rd_acc & w_in_range),
        .a_we    (w_wr_acc),
        .a_be    (s1_byteenable),
        .a_addr  (s1_address[RAM_AW-1:0]),
        .a_wdata (s1_writedata),
        .a_rdata (w_ram_q),
        .b_we    (w_b_we),
        .b_addr  (w_b_addr[RAM_AW-1:0]),
        .b_wdata (st_data)
    );

endmodule
`default_nettype wire

// File: doc/camera_frame_ram_dp.md
Name: camera_frame_ram_dp

Overview:
- Parametrised dual-port on-chip frame buffer. Successor to the single-port CPU scratch RAM.
- Port s1 is an Avalon-MM slave for the Nios/CPU side: pipelined reads with readdatavalid, byte-enabled writes.
- Port s2 is a streaming write sink fed by the camera pixel path. It auto-increments its address, wraps per frame and reports frame completion.
- Sits between the camera capture pipeline and the CPU/MNIST preprocessing software.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 87500, words per frame buffer.
- ADDR_W, 17, address width; must satisfy 2**ADDR_W >= DEPTH.
- FCNT_W, 16, width of the completed-frame counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- s1_address  in  ADDR_W  CPU word address.
- s1_chipselect  in  1  CPU slave select.
- s1_read  in  1  read request.
- s1_write  in  1  write request.
- s1_byteenable  in  DATA_W/8  byte lanes for writes.
- s1_writedata  in  DATA_W  write data.
- s1_readdata  out  DATA_W  read data.
- s1_readdatavalid  out  1  read data qualifier.
- st_valid  in  1  stream word valid.
- st_sop  in  1  first word of frame; qualified by st_valid.
- st_data  in  DATA_W  stream pixel word.
- st_ready  out  1  sink ready.
- capture_en  in  1  capture enable from CSR.
- frame_done  out  1  one-cycle pulse when a frame completes.
- frame_cnt  out  FCNT_W  completed frames; wraps modulo 2**FCNT_W.
- frame_err  out  1  one-cycle pulse on sop arriving mid-frame.

Behaviour:
- Reset values (asynchronous): s1_readdata=0, s1_readdatavalid=0, st_ready=0, frame_done=0, frame_err=0, frame_cnt=0, internal wr_ptr=0, state IDLE. RAM contents are not reset.
- s1 accept: a read is accepted when s1_chipselect & s1_read; a write when s1_chipselect & s1_write. No waitrequest; s1 accepts one transfer every cycle.
- Read latency is 1 cycle. s1_readdatavalid is high exactly one cycle per accepted read; readdata holds its last value otherwise. Back-to-back reads give a continuous valid stream.
- s1 read and write asserted together: treated as a write only; no readdatavalid.
- s1 address >= DEPTH: writes are dropped; reads return 0 with valid asserted at normal latency.
- Writes apply only the enabled byte lanes; disabled lanes keep their old contents.
- st_ready = capture_en, registered: it follows capture_en one cycle later, and is 0 during reset.
- A stream beat is st_valid & st_ready. s2 always writes full words.
- FSM IDLE: ignore beats without sop. A beat with sop writes address 0, sets wr_ptr=1 and moves to CAPTURE.
- FSM CAPTURE: each beat writes wr_ptr, then wr_ptr is incremented.
- Frame completion: a beat at wr_ptr=DEPTH-1 writes that word, sets wr_ptr=0 and returns to IDLE. frame_done pulses the next cycle and frame_cnt increments on that same cycle.
- sop in CAPTURE with wr_ptr != 0: frame_err pulses, and the beat is written to address 0 with wr_ptr=1 (resync). frame_cnt is unchanged.
- capture_en falling mid-frame: wr_ptr and state hold; capture resumes on the next beat.
- Same-address collision (s1 read and s2 write in one cycle): s1 returns the old data.
- Same-address collision (s1 write and s2 write): the s2 data wins.
- Reset mid-frame: the FSM returns to IDLE and wr_ptr=0; partial frame data remains in RAM.

Optional Feature:
- Macro: CAMERA_FRAME_RAM_OUTREG_EN.
- When defined: s1 read data passes through an extra output register. Read latency is 2 cycles and readdatavalid is delayed to match.
- Pipelining behaviour is unchanged otherwise. Out-of-range reads still return 0.
- When undefined: latency is 1 cycle, as specified above.

Decomposition:
- Package camera_frame_ram_pkg holds: the FSM state enum (IDLE, CAPTURE), the default DATA_W/DEPTH/ADDR_W constants, and a byte-lane count function.
- One sub-module, frame_ram_tdp: an inferred true-dual-port RAM with byte-enables on port A, full-word writes on port B, and old-data read-during-write.
- The top level contains the s1 pipeline, the s2 FSM/counter and the flags.

Test Plan:
- Reset, then s1 write 0xDEADBEEF to addr 5 with be=4'b0101, then read addr 5 → readdata=0x00AD00EF (RAM preloaded 0), valid 1 cycle later (2 with OUTREG).
- capture_en=1; stream a full frame (DEPTH=16 in this test), sop on word 0, data=index → frame_done pulse once, frame_cnt=1; s1 reads addr 0..15 return 0..15.
- After 7 beats of a frame, send sop → frame_err pulse, frame_cnt stays 0, new word at addr 0, wr_ptr=1.
- Drop capture_en after beat 4, hold 10 cycles, then re-raise → st_ready low for those 10 cycles, frame completes with no gap in addresses.
- s1 read addr 3 in the same cycle s2 writes 0x55 to addr 3 (old 0x11) → readdata=0x11, next read=0x55. Read addr DEPTH → 0 with valid.
- Assert reset mid-frame at wr_ptr=9 → outputs at reset values; next sop writes addr 0; frame_cnt=0.
